// File: rtl/cmd_issuer.sv
// Command issuer: buffers host commands in a small FIFO and drives them to the unit
// one at a time, handling ATLOC arrival/timeout and a NOOP guard after RESET/SHUTDOWN.
module cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int GUARD   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // Host handshake: a command is taken on any rising edge where cmd_valid and
    // cmd_ready are both high; the host holds the operands stable until then.
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_opcode,
    input  logic [7:0]              cmd_data,
    input  logic [15:0]             cmd_loc,
    output logic [3:0]              opcode,
    output logic [7:0]              DataIn,
    output logic [15:0]             LocIn,
    input  logic [7:0]              DataOut,
    output logic                    done,
    output logic [1:0]              done_status,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [1:0]              dbg_state_o
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GCW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
    localparam logic [GCW-1:0] GUARD_LAST = GCW'(GUARD - 1);
    localparam logic [CW-1:0]  FULL_CNT   = CW'(DEPTH);

    localparam logic [3:0] OP_NOOP     = 4'b0000;
    localparam logic [3:0] OP_ATLOC    = 4'b1010;
    localparam logic [3:0] OP_RESET    = 4'b1100;
    localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ARRIVED = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GUARD} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  data;
        logic [15:0] loc;
    } entry_t;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            ready_en_q;

    state_t          state_q, state_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [7:0]      data_q, data_d;
    logic [15:0]     loc_q, loc_d;
    logic            done_q, done_d;
    logic [1:0]      status_q, status_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [GCW-1:0]  guard_cnt_q, guard_cnt_d;

    logic            push, pop, empty, arrived;
    entry_t          head;
    logic            unused_dataout;

    assign unused_dataout = ^DataOut[7:1];
    assign arrived        = DataOut[0];
    assign empty          = (count_q == '0);
    assign head           = mem_q[rd_ptr_q];

    // ready_en_q keeps the host out until the first edge after reset release.
    assign cmd_ready = ready_en_q && (count_q < FULL_CNT);
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_opcode, data: cmd_data, loc: cmd_loc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            state_q     <= S_IDLE;
            opcode_q    <= OP_NOOP;
            data_q      <= '0;
            loc_q       <= '0;
            done_q      <= 1'b0;
            status_q    <= ST_OK;
            wait_cnt_q  <= '0;
            guard_cnt_q <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            data_q      <= data_d;
            loc_q       <= loc_d;
            done_q      <= done_d;
            status_q    <= status_d;
            wait_cnt_q  <= wait_cnt_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = OP_NOOP;
        data_d      = '0;
        loc_d       = '0;
        done_d      = 1'b0;
        status_d    = ST_OK;
        wait_cnt_d  = wait_cnt_q;
        guard_cnt_d = guard_cnt_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (is_legal(head.op)) begin
                        pop      = 1'b1;
                        state_d  = S_ISSUE;
                        opcode_d = head.op;
                        data_d   = head.data;
                        loc_d    = head.loc;
                    end else if (!done_q) begin
                        // An illegal head waits one cycle if a done is already showing,
                        // so done pulses are always separated by a low cycle.
                        pop      = 1'b1;
                        done_d   = 1'b1;
                        status_d = ST_ILLEGAL;
                    end
                end
            end
            S_ISSUE: begin
                if (opcode_q == OP_ATLOC) begin
                    if (arrived) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        status_d = ST_ARRIVED;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                        opcode_d   = opcode_q;
                        data_d     = data_q;
                        loc_d      = loc_q;
                    end
                end else if (opcode_q == OP_RESET || opcode_q == OP_SHUTDOWN) begin
                    state_d     = S_GUARD;
                    guard_cnt_d = '0;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_WAIT: begin
                // Arrival is checked before timeout so a late arrival still wins.
                if (arrived) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    status_d = ST_ARRIVED;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    status_d = ST_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    opcode_d   = opcode_q;
                    data_d     = data_q;
                    loc_d      = loc_q;
                end
            end
            S_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) state_d = S_IDLE;
                else                           guard_cnt_d = guard_cnt_q + GCW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign opcode      = opcode_q;
    assign DataIn      = data_q;
    assign LocIn       = loc_q;
    assign done        = done_q;
    assign done_status = status_q;
    assign busy        = (state_q != S_IDLE);
    assign fifo_count  = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer: per-feature tasks with hand-computed expectations
// plus an issue-order scoreboard and done-spacing monitor.
module tb_cmd_issuer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int GUARD   = 2;

    localparam logic [3:0] OP_STANDBY  = 4'h4;
    localparam logic [3:0] OP_ATTACK   = 4'h5;
    localparam logic [3:0] OP_GOTO     = 4'h6;
    localparam logic [3:0] OP_TARGET   = 4'h7;
    localparam logic [3:0] OP_RANK     = 4'h8;
    localparam logic [3:0] OP_BATTERY  = 4'h9;
    localparam logic [3:0] OP_ATLOC    = 4'hA;
    localparam logic [3:0] OP_RESET    = 4'hC;
    localparam logic [3:0] OP_SHUTDOWN = 4'hD;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] cmd_loc = '0;
    logic [3:0]  opcode;
    logic [7:0]  DataIn;
    logic [15:0] LocIn;
    logic [7:0]  DataOut = '0;
    logic        done;
    logic [1:0]  done_status;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [27:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [3:0]  prev_op = '0;
    logic        prev_done = 1'b0;
    logic [27:0] mon_e;

    cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .cmd_loc(cmd_loc),
        .opcode(opcode), .DataIn(DataIn), .LocIn(LocIn), .DataOut(DataOut),
        .done(done), .done_status(done_status), .busy(busy),
        .fifo_count(fifo_count), .dbg_state_o(dbg_state)
    );

    function automatic bit legal_op(input logic [3:0] op);
        case (op)
            4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // scoreboard: an issue is a nonzero opcode following a NOOP cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (opcode != 4'h0 && prev_op == 4'h0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL issue_order: unexpected issue got %h/%h/%h, none queued",
                             opcode, DataIn, LocIn);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({opcode, DataIn, LocIn} !== mon_e)
                        $display("FAIL issue_order: got %h exp %h", {opcode, DataIn, LocIn}, mon_e);
                    else n_pass++;
                end
            end
            if (done) begin
                n_checks++;
                if (prev_done !== 1'b0) $display("FAIL done_spacing: done high on two consecutive cycles");
                else n_pass++;
            end
        end
        prev_op   = opcode;
        prev_done = done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] d, input logic [15:0] l);
        logic acc;
        int   cyc;
        acc = 1'b0;
        cyc = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_data   = d;
        cmd_loc    = l;
        while (!acc) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (!acc && cyc > 200) begin
                n_checks++;
                $display("FAIL push_timeout: got cmd_ready=0 for 200 cycles exp acceptance");
                break;
            end
        end
        cmd_valid = 1'b0;
        if (acc && legal_op(op) && op != 4'h0) exp_q.push_back({op, d, l});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_opcode = OP_GOTO; cmd_data = 8'hAA; cmd_loc = 16'hAAAA;
        step(3);
        n_checks++; if (opcode !== 4'h0) $display("FAIL reset_opcode: got %h exp 0", opcode); else n_pass++;
        n_checks++; if (DataIn !== 8'h00) $display("FAIL reset_datain: got %h exp 00", DataIn); else n_pass++;
        n_checks++; if (LocIn !== 16'h0) $display("FAIL reset_locin: got %h exp 0000", LocIn); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else n_pass++;
        n_checks++; if (done_status !== 2'b00) $display("FAIL reset_status: got %b exp 00", done_status); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d exp 0", fifo_count); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", cmd_ready); else n_pass++;
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        step(1);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL count_after_reset: got %0d exp 0", fifo_count); else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_goto();
        step(2);
        push(OP_GOTO, 8'h03, 16'h1234);
        n_checks++; if (fifo_count !== 3'd1) $display("FAIL goto_queued: got %0d exp 1", fifo_count); else n_pass++;
        step(1);
        n_checks++; if ({opcode, DataIn, LocIn} !== {4'h6, 8'h03, 16'h1234})
            $display("FAIL goto_issue: got %h/%h/%h exp 6/03/1234", opcode, DataIn, LocIn); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL goto_busy: got %b exp 1", busy); else n_pass++;
        step(1);
        n_checks++; if (opcode !== 4'h0) $display("FAIL goto_noop: got %h exp 0", opcode); else n_pass++;
        n_checks++; if ({done, done_status} !== 3'b100) $display("FAIL goto_done: got %b%b exp 100", done, done_status); else n_pass++;
        step(1);
        n_checks++; if (done !== 1'b0) $display("FAIL goto_done_pulse: got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [6];
        ops = '{OP_STANDBY, OP_ATTACK, OP_GOTO, OP_TARGET, OP_RANK, OP_BATTERY};
        step(2);
        DataOut = 8'h00;
        push(OP_ATLOC, 8'hA0, 16'hA0A0);
        for (int i = 0; i < 4; i++) push(ops[i], 8'h10 + 8'(i), 16'h1000 + 16'(i));
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_full_count: got %0d exp 4", fifo_count); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b exp 0", cmd_ready); else n_pass++;
        n_checks++; if (opcode !== OP_ATLOC) $display("FAIL b2b_atloc_hold: got %h exp a", opcode); else n_pass++;
        push(ops[4], 8'h14, 16'h1004);
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_refill_count: got %0d exp 4", fifo_count); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_refill_ready: got %b exp 0", cmd_ready); else n_pass++;
        push(ops[5], 8'h15, 16'h1005);
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_last_count: got %0d exp 4", fifo_count); else n_pass++;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1);
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d pending exp 0", exp_q.size()); else n_pass++;
        step(2);
        n_checks++; if ({busy, fifo_count} !== 4'b0000) $display("FAIL b2b_idle: got busy=%b count=%0d exp 0/0", busy, fifo_count); else n_pass++;
    endtask

    task automatic test_atloc_arrival();
        step(2);
        DataOut = 8'h00;
        push(OP_ATLOC, 8'h5A, 16'hCAFE);
        step(1);
        n_checks++; if ({opcode, DataIn, LocIn} !== {4'hA, 8'h5A, 16'hCAFE})
            $display("FAIL arr_issue: got %h/%h/%h exp a/5a/cafe", opcode, DataIn, LocIn); else n_pass++;
        DataOut = 8'hFE;
        step(1);
        n_checks++; if ({busy, opcode} !== 5'b11010) $display("FAIL arr_upper_bits: got busy=%b op=%h exp 1/a", busy, opcode); else n_pass++;
        DataOut = 8'h00;
        step(1);
        n_checks++; if (opcode !== OP_ATLOC) $display("FAIL arr_hold1: got %h exp a", opcode); else n_pass++;
        step(1);
        n_checks++; if (LocIn !== 16'hCAFE) $display("FAIL arr_hold2: got %h exp cafe", LocIn); else n_pass++;
        DataOut = 8'h01;
        step(1);
        n_checks++; if (opcode !== 4'h0) $display("FAIL arr_release: got %h exp 0", opcode); else n_pass++;
        n_checks++; if ({done, done_status} !== 3'b101) $display("FAIL arr_done: got %b%b exp 101", done, done_status); else n_pass++;
        DataOut = 8'h00;
        step(1);
        n_checks++; if (done !== 1'b0) $display("FAIL arr_done_pulse: got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_atloc_timeout();
        int held;
        step(2);
        DataOut = 8'h00;
        held = 0;
        push(OP_ATLOC, 8'h77, 16'h0F0F);
        for (int i = 0; i < 1 + TIMEOUT; i++) begin
            step(1);
            if (opcode === OP_ATLOC) held++;
        end
        n_checks++; if (held != 17) $display("FAIL to_hold: got %0d cycles exp 17", held); else n_pass++;
        step(1);
        n_checks++; if (opcode !== 4'h0) $display("FAIL to_release: got %h exp 0", opcode); else n_pass++;
        n_checks++; if ({done, done_status} !== 3'b110) $display("FAIL to_done: got %b%b exp 110", done, done_status); else n_pass++;
        step(1);
    endtask

    task automatic test_atloc_edges();
        step(2);
        DataOut = 8'h00;
        push(OP_ATLOC, 8'h01, 16'h0001);
        step(TIMEOUT + 1);
        n_checks++; if (opcode !== OP_ATLOC) $display("FAIL late_hold: got %h exp a", opcode); else n_pass++;
        DataOut = 8'h01;
        step(1);
        n_checks++; if ({done, done_status} !== 3'b101) $display("FAIL late_arrival: got %b%b exp 101", done, done_status); else n_pass++;
        DataOut = 8'h00;
        step(2);
        push(OP_ATLOC, 8'h02, 16'h0002);
        DataOut = 8'h01;
        step(1);
        n_checks++; if (opcode !== OP_ATLOC) $display("FAIL early_issue: got %h exp a", opcode); else n_pass++;
        step(1);
        n_checks++; if ({done, done_status, opcode} !== 7'b1010000)
            $display("FAIL early_arrival: got done=%b st=%b op=%h exp 1/01/0", done, done_status, opcode); else n_pass++;
        DataOut = 8'h00;
        step(1);
    endtask

    task automatic test_illegal();
        step(2);
        push(4'h3, 8'hEE, 16'hEEEE);
        push(OP_STANDBY, 8'h11, 16'h2222);
        n_checks++; if ({done, done_status} !== 3'b111) $display("FAIL ill_done: got %b%b exp 111", done, done_status); else n_pass++;
        n_checks++; if ({opcode, fifo_count} !== {4'h0, 3'd1}) $display("FAIL ill_discard: got op=%h count=%0d exp 0/1", opcode, fifo_count); else n_pass++;
        step(1);
        n_checks++; if ({opcode, DataIn, LocIn} !== {4'h4, 8'h11, 16'h2222})
            $display("FAIL ill_next: got %h/%h/%h exp 4/11/2222", opcode, DataIn, LocIn); else n_pass++;
        step(1);
        n_checks++; if ({done, done_status} !== 3'b100) $display("FAIL ill_next_done: got %b%b exp 100", done, done_status); else n_pass++;
        step(2);
        push(4'hF, 8'h00, 16'h0000);
        push(4'hE, 8'h00, 16'h0000);
        n_checks++; if ({done, done_status} !== 3'b111) $display("FAIL ill_pair_first: got %b%b exp 111", done, done_status); else n_pass++;
        step(1);
        n_checks++; if ({done, fifo_count} !== {1'b0, 3'd1}) $display("FAIL ill_pair_gap: got done=%b count=%0d exp 0/1", done, fifo_count); else n_pass++;
        step(1);
        n_checks++; if ({done, done_status, fifo_count} !== {3'b111, 3'd0})
            $display("FAIL ill_pair_second: got done=%b st=%b count=%0d exp 1/11/0", done, done_status, fifo_count); else n_pass++;
        step(1);
    endtask

    task automatic test_guard();
        step(2);
        push(OP_RESET, 8'h01, 16'h0002);
        push(OP_RANK, 8'h33, 16'h4444);
        n_checks++; if ({opcode, DataIn, LocIn} !== {4'hC, 8'h01, 16'h0002})
            $display("FAIL grd_issue: got %h/%h/%h exp c/01/0002", opcode, DataIn, LocIn); else n_pass++;
        step(1);
        n_checks++; if ({opcode, done, done_status, busy} !== {4'h0, 3'b100, 1'b1})
            $display("FAIL grd_first: got op=%h done=%b st=%b busy=%b exp 0/1/00/1", opcode, done, done_status, busy); else n_pass++;
        step(1);
        n_checks++; if ({opcode, done, busy} !== {4'h0, 1'b0, 1'b1})
            $display("FAIL grd_second: got op=%h done=%b busy=%b exp 0/0/1", opcode, done, busy); else n_pass++;
        step(1);
        n_checks++; if ({opcode, busy} !== {4'h0, 1'b0}) $display("FAIL grd_exit: got op=%h busy=%b exp 0/0", opcode, busy); else n_pass++;
        step(1);
        n_checks++; if ({opcode, LocIn} !== {4'h8, 16'h4444}) $display("FAIL grd_rank: got %h/%h exp 8/4444", opcode, LocIn); else n_pass++;
        step(3);
        push(OP_SHUTDOWN, 8'h00, 16'h0000);
        step(2);
        n_checks++; if ({done, busy} !== 2'b11) $display("FAIL shut_guard: got done=%b busy=%b exp 1/1", done, busy); else n_pass++;
        step(2);
        n_checks++; if (busy !== 1'b0) $display("FAIL shut_exit: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_reset_wait();
        step(2);
        DataOut = 8'h00;
        push(OP_ATLOC, 8'h44, 16'h5555);
        push(OP_GOTO, 8'h66, 16'h7777);
        step(2);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({opcode, DataIn, LocIn} !== 28'h0)
            $display("FAIL rstw_outputs: got %h/%h/%h exp 0/00/0000", opcode, DataIn, LocIn); else n_pass++;
        n_checks++; if ({busy, done, fifo_count, cmd_ready} !== 6'b000000)
            $display("FAIL rstw_state: got busy=%b done=%b count=%0d ready=%b exp all 0", busy, done, fifo_count, cmd_ready); else n_pass++;
        exp_q.delete();
        step(1);
        rst_n = 1'b1;
        step(1);
        n_checks++; if ({done, cmd_ready} !== 2'b01) $display("FAIL rstw_release: got done=%b ready=%b exp 0/1", done, cmd_ready); else n_pass++;
        step(3);
        n_checks++; if ({opcode, busy, fifo_count} !== 8'h00)
            $display("FAIL rstw_flushed: got op=%h busy=%b count=%0d exp 0/0/0", opcode, busy, fifo_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_goto();
        test_back_to_back();
        test_atloc_arrival();
        test_atloc_timeout();
        test_atloc_edges();
        test_illegal();
        test_guard();
        test_reset_wait();
        step(2);
        n_checks++; if (exp_q.size() != 0) $display("FAIL final_drain: got %0d pending exp 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
